// File: rtl/audio_level_meter.sv
// rtl/audio_level_meter.sv - pops stereo words from the capture FIFO and tracks per-channel peak levels
// with hold and exponential decay.
module audio_level_meter #(
  parameter int SAMPLE_W     = 16,
  parameter int LEVEL_W      = 8,
  parameter int HOLD_SAMPLES = 2400,
  parameter int DECAY_SHIFT  = 6
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [2*SAMPLE_W-1:0] FIFO_Q,
  input  logic                  FIFO_RDEMPTY,
  input  logic                  FIFO_RDFULL,
  output logic                  FIFO_RDREQ,
  input  logic                  CLEAR,
  output logic [LEVEL_W-1:0]    LEVEL_L,
  output logic [LEVEL_W-1:0]    LEVEL_R,
  output logic                  LEVEL_VALID,
  output logic                  OVERRUN,
  output logic [15:0]           SAMPLE_CNT
);

  localparam int MAG_W  = SAMPLE_W - 1;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_PROCESS
  } state_t;

  state_t               state_q, state_d;
  logic                 rdreq_q, rdreq_d;
  logic [SAMPLE_W-1:0]  s_l_q, s_l_d;
  logic [SAMPLE_W-1:0]  s_r_q, s_r_d;
  logic [MAG_W-1:0]     peak_l_q, peak_l_d;
  logic [MAG_W-1:0]     peak_r_q, peak_r_d;
  logic [HOLD_W-1:0]    hold_l_q, hold_l_d;
  logic [HOLD_W-1:0]    hold_r_q, hold_r_d;
  logic [LEVEL_W-1:0]   level_l_q, level_l_d;
  logic [LEVEL_W-1:0]   level_r_q, level_r_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [MAG_W-1:0]     mag_l, mag_r;

  // Negating the most negative sample overflows back to itself, which is where the MSB test saturates.
  function automatic logic [MAG_W-1:0] magnitude(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = ~s + 1'b1;
    if (!s[SAMPLE_W-1]) magnitude = s[MAG_W-1:0];
    else if (neg[SAMPLE_W-1]) magnitude = '1;
    else magnitude = neg[MAG_W-1:0];
  endfunction

  function automatic logic [MAG_W-1:0] decay(input logic [MAG_W-1:0] peak);
    logic [MAG_W-1:0] step;
    step = peak >> DECAY_SHIFT;
    if (step == '0) step = MAG_W'(1);
    decay = peak - step;
  endfunction

  function automatic logic [HOLD_W+MAG_W-1:0] track(input logic [MAG_W-1:0]  mag,
                                                    input logic [MAG_W-1:0]  peak,
                                                    input logic [HOLD_W-1:0] hold);
    if (mag >= peak) track = {HOLD_W'(HOLD_SAMPLES), mag};
    else if (hold != '0) track = {hold - HOLD_W'(1), peak};
    else if (peak != '0) track = {hold, decay(peak)};
    else track = {hold, peak};
  endfunction

  assign mag_l = magnitude(s_l_q);
  assign mag_r = magnitude(s_r_q);

  always_comb begin
    state_d   = state_q;
    s_l_d     = s_l_q;
    s_r_d     = s_r_q;
    peak_l_d  = peak_l_q;
    peak_r_d  = peak_r_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    level_l_d = level_l_q;
    level_r_d = level_r_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!FIFO_RDEMPTY) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        s_l_d   = FIFO_Q[2*SAMPLE_W-1 -: SAMPLE_W];
        s_r_d   = FIFO_Q[SAMPLE_W-1:0];
        state_d = S_PROCESS;
      end
      S_PROCESS: begin
        {hold_l_d, peak_l_d} = track(mag_l, peak_l_q, hold_l_q);
        {hold_r_d, peak_r_d} = track(mag_r, peak_r_q, hold_r_q);
        level_l_d = peak_l_d[MAG_W-1 -: LEVEL_W];
        level_r_d = peak_r_d[MAG_W-1 -: LEVEL_W];
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered decode: the request flop is high exactly while the FSM sits in READ.
    rdreq_d = (state_d == S_READ);
  end

  always_comb begin
    overrun_d = FIFO_RDFULL | (overrun_q & ~CLEAR);
    cnt_d     = cnt_q;
    if (CLEAR) cnt_d = '0;
    else if (state_q == S_PROCESS) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      rdreq_q   <= 1'b0;
      s_l_q     <= '0;
      s_r_q     <= '0;
      peak_l_q  <= '0;
      peak_r_q  <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      level_l_q <= '0;
      level_r_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rdreq_q   <= rdreq_d;
      s_l_q     <= s_l_d;
      s_r_q     <= s_r_d;
      peak_l_q  <= peak_l_d;
      peak_r_q  <= peak_r_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      level_l_q <= level_l_d;
      level_r_q <= level_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign FIFO_RDREQ  = rdreq_q;
  assign LEVEL_L     = level_l_q;
  assign LEVEL_R     = level_r_q;
  assign LEVEL_VALID = valid_q;
  assign OVERRUN     = overrun_q;
  assign SAMPLE_CNT  = cnt_q;

endmodule

// File: doc/audio_level_meter.md
# audio_level_meter

Consumer stage on the CLOCK_50 side of the audio capture FIFO: pops 32-bit stereo sample words from the dual-clock FIFO, converts each channel to a saturated magnitude, and tracks a per-channel peak with hold and exponential decay. Exposes registered 8-bit left/right levels and a valid strobe for the VGA bar renderer, plus a sticky overrun flag that is set when the FIFO is seen full.

## Interface

Parameters:
- SAMPLE_W, 16: width of one channel sample, signed two's complement.
- LEVEL_W, 8: width of the LEVEL_L and LEVEL_R outputs.
- HOLD_SAMPLES, 2400: number of samples a new peak is held before decay starts.
- DECAY_SHIFT, 6: per-sample decay is peak >> DECAY_SHIFT, with a minimum of 1.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock (CLOCK_50).
- RESET_N  in  1  asynchronous active-low reset.
- FIFO_Q  in  2*SAMPLE_W  FIFO read data. Left channel is in the upper half, right channel in the lower half.
- FIFO_RDEMPTY  in  1  FIFO empty, read-side domain.
- FIFO_RDFULL  in  1  FIFO full, read-side domain.
- FIFO_RDREQ  out  1  FIFO read request.
- CLEAR  in  1  synchronous clear of OVERRUN and SAMPLE_CNT.
- LEVEL_L  out  LEVEL_W  left peak level, equal to peak_l[SAMPLE_W-2 -: LEVEL_W].
- LEVEL_R  out  LEVEL_W  right peak level, same mapping.
- LEVEL_VALID  out  1  one-cycle strobe when LEVEL_L and LEVEL_R are updated.
- OVERRUN  out  1  sticky flag, set when FIFO_RDFULL is seen.
- SAMPLE_CNT  out  16  count of processed samples, wraps at 2^16.

## Operation

- The FIFO is in normal (non-show-ahead) mode, so FIFO_Q is valid the cycle after FIFO_RDREQ.
- The FSM has 4 states: IDLE, READ, CAPTURE, PROCESS.
  - IDLE: go to READ when FIFO_RDEMPTY=0; otherwise stay.
  - READ: FIFO_RDREQ=1 for exactly this one cycle, then CAPTURE.
  - CAPTURE: register FIFO_Q into s_l and s_r, then PROCESS.
  - PROCESS: update both peaks, update hold counters, increment SAMPLE_CNT, then IDLE.
- FIFO_RDREQ is a registered decode of state==READ. It is never asserted while FIFO_RDEMPTY was 1 in the preceding IDLE cycle.
- Magnitude: mag = |s|, kept at SAMPLE_W-1 bits.
  - The most negative value (-2^(SAMPLE_W-1), i.e. 0x8000 at SAMPLE_W=16) saturates to 2^(SAMPLE_W-1)-1 (0x7FFF).
- Peak update, per channel, in PROCESS, first matching rule wins:
  - If mag >= peak: peak <= mag and hold <= HOLD_SAMPLES.
  - Else if hold != 0: hold <= hold-1 and peak is unchanged.
  - Else if peak != 0: peak <= peak - max(peak>>DECAY_SHIFT, 1).
  - Else: peak stays 0.
- Peak never underflows below 0.
- The hold counter is wide enough for HOLD_SAMPLES, i.e. $clog2(HOLD_SAMPLES+1) bits.
- The left and right channels are fully independent.
- OVERRUN is set on any cycle with FIFO_RDFULL=1.
  - CLEAR=1 clears OVERRUN and SAMPLE_CNT.
  - If set and clear happen in the same cycle, set wins.
  - CLEAR does not touch the peaks or the FSM.

## Timing

- Reset values: FSM=IDLE, FIFO_RDREQ=0, LEVEL_L=0, LEVEL_R=0, LEVEL_VALID=0, OVERRUN=0, SAMPLE_CNT=0, peaks=0, holds=0.
- Reset acts asynchronously mid-operation:
  - If reset hits during READ, FIFO_RDREQ drops immediately.
  - A word popped but not yet processed is discarded. This is accepted.
- Latency: FIFO_RDREQ in cycle t, capture in t+1, PROCESS in t+2. LEVEL_L, LEVEL_R and LEVEL_VALID are registered and change in t+3.
- Throughput: one sample per 4 cycles when the FIFO is continuously non-empty (IDLE→READ→CAPTURE→PROCESS→IDLE).
- LEVEL_VALID pulses exactly once per processed sample, even when the level value does not change.
- Between strobes, LEVEL_L and LEVEL_R hold their values.
- FIFO_RDEMPTY rising while the FSM is in CAPTURE or PROCESS has no effect on the sample in flight.

## Test plan

- Reset, then one word 0x4000_C000 → FIFO_RDREQ high for exactly 1 cycle.
  - 3 cycles later: LEVEL_L=0x80, LEVEL_R=0x80, LEVEL_VALID pulses once, SAMPLE_CNT=1.
- Word 0x8000_7FFF → both magnitudes 0x7FFF, LEVEL_L=0xFF, LEVEL_R=0xFF (saturation check).
- Peak 0x7FFF followed by 2400 zero samples → level stays 0xFF for all 2400.
  - On sample 2401 the peak becomes 0x7FFF-0x1FF=0x7E00.
  - With further zero samples it decays monotonically to exactly 0 and stays there.
- FIFO_RDEMPTY held at 1 → FIFO_RDREQ never asserts and LEVEL_VALID stays 0.
  - Deassert FIFO_RDEMPTY for 1 word, then reassert → exactly one read.
- Pulse FIFO_RDFULL → OVERRUN=1 next cycle and stays set.
  - CLEAR alone → OVERRUN=0, SAMPLE_CNT=0.
  - CLEAR together with FIFO_RDFULL → OVERRUN stays 1.
- Assert RESET_N=0 during the READ cycle → FIFO_RDREQ=0 immediately and all outputs return to reset values.
  - After release, the next word is processed normally.
